seq_restoring_divider: RTL and testbench

//   Iterative unsigned restoring divider. It is the inverse datapath of the

---
 rtl/seq_restoring_divider.sv | 77 +++++++
 tb/tb_seq_restoring_divider.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               overflow,
  output logic               div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, state_nx;
  logic [WIDTH:0] r, t;
  logic [WIDTH-1:0] s, d;
  logic [CW-1:0] cnt;
  logic ovf, dz, accept, ovf_in, ge;
  always_comb begin
    accept = state == IDLE && start && !done;
    ovf_in = divisor == '0 || dividend[2*WIDTH-1:WIDTH] >= divisor;
    t = {r[WIDTH-1:0], s[WIDTH-1]};
    ge = t >= {1'b0, d};
    state_nx = accept ? (ovf_in ? FIN : CALC) :
               state == CALC && cnt == CW'(1) ? FIN :
               state == FIN ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
      r <= '0;
      s <= '0;
      d <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      dz <= 1'b0;
    end else begin
      state <= state_nx;
      busy <= accept || state == CALC;
      done <= state == FIN;
      if (accept) begin
        d <= divisor;
        r <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
        s <= dividend[WIDTH-1:0];
        cnt <= CW'(WIDTH);
        ovf <= ovf_in;
        dz <= divisor == '0;
        quotient <= '0;
        remainder <= '0;
        overflow <= 1'b0;
        div_zero <= 1'b0;
      end
      if (state == CALC) begin
        r <= ge ? t - {1'b0, d} : t;
        s <= {s[WIDTH-2:0], ge};
        cnt <= cnt - CW'(1);
      end
      if (state == FIN) begin
        quotient <= ovf ? '1 : s;
        remainder <= ovf ? '0 : r[WIDTH-1:0];
        overflow <= ovf;
        div_zero <= dz;
      end
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: table, round-trip and corner-case checks with a result scoreboard
module tb_seq_restoring_divider;
  localparam int W = 4;
  typedef struct {logic [W-1:0] q, r; logic ov, dz;} res_t;
  typedef struct {logic [2*W-1:0] dd; logic [W-1:0] dv; res_t e; int lat;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic busy, done, overflow, div_zero, done_q = 1'b0;
  logic [W-1:0] quotient, remainder;
  res_t sb[$];
  res_t m_e;
  vec_t tbl[8];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .overflow(overflow), .div_zero(div_zero)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (done_q) begin
        n_vec++;
        n_err++;
        $display("FAIL done_width: got 2-cycle done expected 1-cycle pulse");
      end
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done with q=%0d r=%0d expected no done", quotient, remainder);
      end else begin
        m_e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(m_e.q));
        chk("remainder", 32'(remainder), 32'(m_e.r));
        chk("overflow", 32'(overflow), 32'(m_e.ov));
        chk("div_zero", 32'(div_zero), 32'(m_e.dz));
      end
    end
    done_q = rst_n && done;
  end
  task automatic wait_done(input int lat);
    int k = 0;
    logic got = 1'b0;
    while (!got && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got no done in %0d cycles expected done", k);
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (lat > 0) chk("latency", 32'(k), 32'(lat));
  endtask
  task automatic run_div(input logic [2*W-1:0] dd, input logic [W-1:0] dv, input res_t e, input int lat);
    @(negedge clk);
    dividend = dd;
    divisor = dv;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(lat);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{8'd200, 4'd13, '{4'd15, 4'd5,  1'b0, 1'b0}, 5};
    tbl[1] = '{8'd240, 4'd15, '{4'd15, 4'd0,  1'b1, 1'b0}, 1};
    tbl[2] = '{8'd37,  4'd0,  '{4'd15, 4'd0,  1'b1, 1'b1}, 1};
    tbl[3] = '{8'd239, 4'd15, '{4'd15, 4'd14, 1'b0, 1'b0}, 5};
    tbl[4] = '{8'd16,  4'd1,  '{4'd15, 4'd0,  1'b1, 1'b0}, 1};
    tbl[5] = '{8'd15,  4'd1,  '{4'd15, 4'd0,  1'b0, 1'b0}, 5};
    tbl[6] = '{8'd0,   4'd9,  '{4'd0,  4'd0,  1'b0, 1'b0}, 5};
    tbl[7] = '{8'd100, 4'd7,  '{4'd14, 4'd2,  1'b0, 1'b0}, 5};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_div(tbl[i].dd, tbl[i].dv, tbl[i].e, tbl[i].lat);
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        run_div(8'(a * b), 4'(b), '{4'(a), 4'd0, 1'b0, 1'b0}, 5);
    @(negedge clk);
    dividend = 8'd100;
    divisor = 4'd7;
    start = 1'b1;
    sb.push_back('{4'd14, 4'd2, 1'b0, 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 8'd9;
    divisor = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0);
    repeat (10) @(negedge clk);
    chk("busy_idle_after_ignored_start", 32'(busy), 32'd0);
    @(negedge clk);
    dividend = 8'd200;
    divisor = 4'd13;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    chk("abort_div_zero", 32'(div_zero), 32'd0);
    repeat (10) @(negedge clk);
    run_div(8'd50, 4'd6, '{4'd8, 4'd2, 1'b0, 1'b0}, 5);
    @(negedge clk);
    chk("done_dropped", 32'(done), 32'd0);
    chk("held_quotient", 32'(quotient), 32'd8);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
